// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// optional parity and 1/2 stop bits, single-word holding register with overrun flag.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srl_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_timer;
    logic [3:0]           r_bitcnt;
    logic                 r_stopcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid, r_perr_out, r_ferr_out, r_ovr;

    logic w_rx, w_hit, w_deliver, w_par_exp, w_ferr_fin;

    assign w_rx       = r_sync[1];
    assign w_par_exp  = (^r_shift) ^ (PARITY == 1);
    assign w_ferr_fin = r_ferr | ~w_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
        end else begin
            r_sync  <= {r_sync[0], srl_in};
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deliver   = 1'b0;
        w_hit       = (r_state == S_START) ? (r_timer == HALF_M1) : (r_timer == FULL_M1);
        case (r_state)
            S_IDLE:      if (!w_rx) w_state_nxt = S_START;
            S_START:     if (w_hit) w_state_nxt = w_rx ? S_IDLE : S_DATA;
            S_DATA:      if (w_hit && r_bitcnt == LAST_BIT)
                             w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_hit) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_hit && r_stopcnt == LAST_STP) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = w_rx ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: if (w_rx) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Timer is held at zero outside a frame so START always begins from a clean count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT_HIGH || w_hit)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            if (r_state == S_IDLE) begin
                r_bitcnt  <= '0;
                r_stopcnt <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end

            if (w_hit) begin
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                    S_PARITY: r_perr <= w_rx ^ w_par_exp;
                    S_STOP: begin
                        r_ferr    <= w_ferr_fin;
                        r_stopcnt <= r_stopcnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A held word is only replaced if the consumer takes it on the delivery edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || data_ready) begin
                    r_data_out <= r_shift;
                    r_perr_out <= r_perr;
                    r_ferr_out <= w_ferr_fin;
                    r_valid    <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_valid;
    assign parity_err  = r_perr_out;
    assign frame_err   = r_ferr_out;
    assign overrun_err = r_ovr;
    assign busy        = (r_state != S_IDLE);
endmodule
